// File: rtl/multicycle_ctrl24.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl24
//   Control unit for a small multi-cycle 24-bit core. Holds the instruction
//   register and sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH,
//   driving ALU, register-file, data-memory and PC control strobes.
//
//   Optional feature macro: ILLEGAL_TRAP_EN
//     defined   : opcodes 8..E stop the core (HALT) with illegal=1
//     undefined : opcodes 8..E execute as a NOP and illegal is tied to 0
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   instr_valid, instr  instruction word offered by instruction memory
//   instr_ready         word on instr is accepted this cycle (FETCH)
//   alu_z               ALU zero flag, used by BEQZ
//   mem_ack             data memory finished the current request
//   alu_op, alu_src_imm ALU operation and operand-B select
//   imm_out, br_offset  zero-extended imm8 / sign-extended imm8
//   rd/rs/rt_addr       register-file addresses taken from IR
//   reg_we, wb_sel_mem  register write strobe and write-data source
//   mem_req, mem_we     data-memory request and write qualifier
//   pc_en, pc_branch    PC advance and branch select
//   halted, illegal     core stopped / stopped on an illegal opcode
// -----------------------------------------------------------------------------
module multicycle_ctrl24 (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [23:0] instr,
    output logic        instr_ready,
    input  logic        alu_z,
    input  logic        mem_ack,
    output logic [2:0]  alu_op,
    output logic        alu_src_imm,
    output logic [23:0] imm_out,
    output logic [23:0] br_offset,
    output logic [3:0]  rd_addr,
    output logic [3:0]  rs_addr,
    output logic [3:0]  rt_addr,
    output logic        reg_we,
    output logic        wb_sel_mem,
    output logic        mem_req,
    output logic        mem_we,
    output logic        pc_en,
    output logic        pc_branch,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_MUL   = 4'h1,
        OP_LI    = 4'h2,
        OP_LOAD  = 4'h3,
        OP_STORE = 4'h4,
        OP_ORI   = 4'h5,
        OP_LUI   = 4'h6,
        OP_BEQZ  = 4'h7,
        OP_HALT  = 4'hF
    } op_e;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_MUL   = 3'b001;
    localparam logic [2:0] ALU_PASSB = 3'b010;
    localparam logic [2:0] ALU_ADDR  = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SHL8  = 3'b101;

    state_e      state_q, state_d;
    logic [23:0] ir_q, ir_d;

    logic [3:0]  opcode;
    logic        op_illegal;

    assign opcode = ir_q[23:20];
    // 8..E: top bit set but not the all-ones HALT encoding
    assign op_illegal = ir_q[23] && (ir_q[23:20] != 4'hF);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (op_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_BEQZ:           state_d = S_FETCH;
                    default:           state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = (opcode == OP_LOAD) ? S_WB : S_FETCH;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Field outputs follow IR in every state; rt is zeroed only for BEQZ in
    // EXEC so operand B reads R0 and alu_z reflects R[rs] == 0.
    assign rd_addr   = ir_q[19:16];
    assign rs_addr   = ir_q[15:12];
    assign rt_addr   = (state_q == S_EXEC && opcode == OP_BEQZ) ? 4'd0 : ir_q[11:8];
    assign imm_out   = {16'd0, ir_q[7:0]};
    assign br_offset = {{16{ir_q[7]}}, ir_q[7:0]};

    always_comb begin
        instr_ready = 1'b0;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel_mem  = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        pc_en       = 1'b0;
        pc_branch   = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_FETCH: instr_ready = 1'b1;
            S_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
                // illegal opcode retires here as a NOP
                pc_en = op_illegal;
`endif
            end
            S_EXEC: begin
                case (opcode)
                    OP_ADD:   alu_op = ALU_ADD;
                    OP_MUL:   alu_op = ALU_MUL;
                    OP_LI:    begin alu_op = ALU_PASSB; alu_src_imm = 1'b1; end
                    OP_LOAD,
                    OP_STORE: begin alu_op = ALU_ADDR;  alu_src_imm = 1'b1; end
                    OP_ORI:   begin alu_op = ALU_OR;    alu_src_imm = 1'b1; end
                    OP_LUI:   begin alu_op = ALU_SHL8;  alu_src_imm = 1'b1; end
                    OP_BEQZ:  begin
                        alu_op    = ALU_ADD;
                        pc_en     = 1'b1;
                        pc_branch = alu_z;
                    end
                    default:  alu_op = ALU_ADD;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_STORE);
                // a store retires in the cycle its ack arrives
                pc_en   = (opcode == OP_STORE) && mem_ack;
            end
            S_WB: begin
                reg_we     = 1'b1;
                wb_sel_mem = (opcode == OP_LOAD);
                pc_en      = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state_q == S_HALT) && op_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule
